// File: rtl/control_unit.sv
// Instruction sequencer: fetch/decode of 16-bit instructions into the
// ALU/ACC/BR/memory control word, with jump resolution from ALU flags.
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    input  logic [3:0]  alu_flags,
    output logic [15:0] control_signals,
    output logic [7:0]  mem_addr,
    output logic [7:0]  pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_CLR,
        S_CLRWB,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h09;
    localparam logic [7:0] OP_OR     = 8'h0A;
    localparam logic [7:0] OP_NOT    = 8'h0B;
    localparam logic [7:0] OP_SHR    = 8'h0C;
    localparam logic [7:0] OP_SHL    = 8'h0D;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_CLR  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_MPY  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_NOT  = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_SHR  = 4'd9;

    localparam logic [15:0] CS_ACC_LD = 16'h0800;
    localparam logic [15:0] CS_BR_LD  = 16'h0400;
    localparam logic [15:0] CS_MEM_WE = 16'h0200;

    state_t      state;
    state_t      state_n;
    logic [15:0] ir;
    logic [15:0] ir_n;
    logic [7:0]  pc_n;
    logic [7:0]  opc;
    logic [7:0]  opx;
    logic [15:0] ctrl_n;
    logic [7:0]  addr_n;
    logic        unused_flags;

    assign opc = ir[15:8];
    assign opx = ir[7:0];

    // Only the sign flag steers control flow.
    assign unused_flags = ^alu_flags[3:1];

    function automatic logic [3:0] alu_code(input logic [7:0] op);
        logic [3:0] code;
        code = ALU_NONE;
        case (op)
            OP_LOAD: code = ALU_ADD;
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_MPY:  code = ALU_MPY;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_NOT:  code = ALU_NOT;
            OP_SHL:  code = ALU_SHL;
            OP_SHR:  code = ALU_SHR;
            default: code = ALU_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [15:0] ctrl_for(
        input state_t      s,
        input logic [15:0] i
    );
        logic [15:0] c;
        c = 16'h0000;
        unique case (s)
            S_MEM:   c = (i[15:8] == OP_STORE) ? CS_MEM_WE : CS_BR_LD;
            S_CLR:   c = {ALU_CLR, 12'h000};
            S_CLRWB: c = CS_ACC_LD;
            S_EXEC:  c = {alu_code(i[15:8]), 12'h000};
            S_WB:    c = CS_ACC_LD;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        unique case (state)
            S_FETCH: begin
                if (run) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc + 8'd1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_FETCH;
                case (opc)
                    OP_JMP: pc_n = opx;
                    OP_JMPGEZ: begin
                        if (!alu_flags[0]) pc_n = opx;
                    end
                    OP_HALT: state_n = S_HALT;
                    OP_NOT, OP_SHR, OP_SHL: state_n = S_EXEC;
                    OP_STORE, OP_LOAD, OP_ADD, OP_SUB,
                    OP_MPY, OP_AND, OP_OR: state_n = S_MEM;
                    default: state_n = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (opc == OP_STORE)     state_n = S_FETCH;
                else if (opc == OP_LOAD) state_n = S_CLR;
                else                     state_n = S_EXEC;
            end
            S_CLR:   state_n = S_CLRWB;
            S_CLRWB: state_n = S_EXEC;
            S_EXEC:  state_n = S_WB;
            S_WB:    state_n = S_FETCH;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they never see inputs
    // combinationally.
    assign ctrl_n = ctrl_for(state_n, ir_n);
    assign addr_n = (state_n == S_MEM) ? ir_n[7:0] : pc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_FETCH;
            pc              <= RESET_PC;
            ir              <= 16'h0000;
            control_signals <= 16'h0000;
            mem_addr        <= RESET_PC;
            halted          <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            ir              <= ir_n;
            control_signals <= ctrl_n;
            mem_addr        <= addr_n;
            halted          <= (state_n == S_HALT);
        end
    end

endmodule
